// File: rtl/snake_pkg.sv
// Shared types for the snake bitmap engine: cell position, FSM state and
// the cell-to-bit-index mapping used by the decoders.
package snake_pkg;

   localparam int DEF_COLS  = 16;
   localparam int DEF_ROWS  = 8;
   localparam int DEF_COL_W = 4;
   localparam int DEF_ROW_W = 3;

   typedef struct packed {
      logic [DEF_ROW_W-1:0] row;
      logic [DEF_COL_W-1:0] col;
   } cell_t;

   typedef enum logic [1:0] {
      CLEAR,
      RUN,
      HALT
   } state_t;

   function automatic int cell_index(input int row, input int col, input int cols);
      return row * cols + col;
   endfunction

endpackage

// File: rtl/snake_cell_decode.sv
// Turns a {row,col} position into a one-hot pixel mask; the mask is empty
// when the position lies outside the grid.
module snake_cell_decode
   import snake_pkg::*;
#(
   parameter int COLS  = 16,
   parameter int ROWS  = 8,
   parameter int COL_W = 4,
   parameter int ROW_W = 3
) (
   input  logic [ROW_W+COL_W-1:0] pos,
   output logic [ROWS*COLS-1:0]   mask,
   output logic                   in_range
);

   localparam int N = ROWS * COLS;
   localparam logic [N-1:0] ONE_HOT0 = N'(1);

   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;

   assign row = pos[COL_W +: ROW_W];
   assign col = pos[COL_W-1:0];

   always_comb begin
      in_range = (int'(row) < ROWS) && (int'(col) < COLS);
      mask     = '0;
      if (in_range) begin
         mask = ONE_HOT0 << cell_index(int'(row), int'(col), COLS);
      end
   end

endmodule

// File: rtl/snake_bitmap_engine.sv
// Snake-body bitmap: sets the head pixel and vacates the tail on each move,
// tracks pending growth from food and flags body/wall collisions.
module snake_bitmap_engine
   import snake_pkg::*;
#(
   parameter int COLS           = 16,
   parameter int ROWS           = 8,
   parameter int COL_W          = 4,
   parameter int ROW_W          = 3,
   parameter int GROW_LEN       = 1,
   parameter bit PIX_ACTIVE_LOW = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   step_valid,
   output logic                   step_ready,
   input  logic [ROW_W+COL_W-1:0] head_pos,
   input  logic [ROW_W+COL_W-1:0] tail_pos,
   input  logic [ROW_W+COL_W-1:0] food_pos,
   output logic [ROWS*COLS-1:0]   pixels,
   output logic                   eaten,
   output logic                   game_over,
   output logic                   busy
);

   localparam int N  = ROWS * COLS;
   localparam int GW = $clog2(ROWS * COLS + 1);
   localparam logic [N-1:0] ROW0_MASK = N'({COLS{1'b1}});

   logic [N-1:0]     head_mask, tail_mask;
   logic             head_in, tail_in;
   state_t           state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [GW-1:0]    grow_q, grow_d, grow_tmp;
   logic [GW:0]      grow_sum;
   logic             eaten_q, eaten_d;
   logic             over_q, over_d;
   logic [N-1:0]     bitmap_q, bitmap_d;
   logic             collide;

   snake_cell_decode #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W)) u_head_dec (
      .pos      (head_pos),
      .mask     (head_mask),
      .in_range (head_in)
   );

   snake_cell_decode #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W)) u_tail_dec (
      .pos      (tail_pos),
      .mask     (tail_mask),
      .in_range (tail_in)
   );

   assign step_ready = (state_q == RUN);
   assign busy       = (state_q == CLEAR);
   assign eaten      = eaten_q;
   assign game_over  = over_q;
   assign pixels     = PIX_ACTIVE_LOW ? ~bitmap_q : bitmap_q;

   // Stepping onto the tail cell is only safe when the tail really moves away.
   assign collide = !head_in ||
                    ((|(bitmap_q & head_mask)) && ((head_pos != tail_pos) || (grow_q != '0)));

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      grow_d   = grow_q;
      grow_tmp = grow_q;
      grow_sum = '0;
      eaten_d  = 1'b0;
      over_d   = over_q;
      bitmap_d = bitmap_q;

      if (start) begin
         state_d = CLEAR;
         row_d   = '0;
         grow_d  = '0;
         over_d  = 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               bitmap_d = bitmap_q & ~(ROW0_MASK << (int'(row_q) * COLS));
               if (row_q == ROW_W'(ROWS - 1)) begin
                  state_d = RUN;
                  row_d   = '0;
               end else begin
                  row_d = row_q + ROW_W'(1);
               end
            end
            RUN: begin
               if (step_valid && step_ready) begin
                  if (collide) begin
                     over_d  = 1'b1;
                     state_d = HALT;
                  end else begin
                     if (grow_q == '0) begin
                        bitmap_d = bitmap_q & ~(tail_in ? tail_mask : '0);
                     end else begin
                        grow_tmp = grow_q - GW'(1);
                     end
                     bitmap_d = bitmap_d | head_mask;
                     // Pending growth is consumed first, then the new food is added with saturation.
                     if (head_pos == food_pos) begin
                        eaten_d  = 1'b1;
                        grow_sum = {1'b0, grow_tmp} + (GW+1)'(GROW_LEN);
                        grow_d   = grow_sum[GW] ? '1 : grow_sum[GW-1:0];
                     end else begin
                        grow_d = grow_tmp;
                     end
                  end
               end
            end
            HALT: begin
            end
            default: begin
               state_d = CLEAR;
               row_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= CLEAR;
         row_q    <= '0;
         grow_q   <= '0;
         eaten_q  <= 1'b0;
         over_q   <= 1'b0;
         bitmap_q <= '0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         grow_q   <= grow_d;
         eaten_q  <= eaten_d;
         over_q   <= over_d;
         bitmap_q <= bitmap_d;
      end
   end

endmodule
